imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Registered, flow-controlled immediate generator for the decode stage, parametrised in datapath width (XLEN = 32 or 64). It decodes one 32-bit instruction per cycle into a sign- or zero-extended immediate and adds a 6-bit shift-amount format. Results pass through a 2-entry output buffer with valid/ready handshakes on both sides and a per-entry tag. The block sits between instruction fetch/decode and the ID/EX register, so back-pressure from EX stalls it without losing data.

## Interface
- XLEN, 64, immediate width; legal values are 32 and 64, any other value is an elaboration error.
- TAG_W, 4, width of the opaque tag carried alongside each result.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  request valid.
- in_ready  out  1  buffer can accept a request this cycle.
- in_op  in  3  format select: 0 zero, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR, 7 SHAMT.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  tag, returned unmodified with the result.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_imm  out  XLEN  immediate of the head entry.
- out_tag  out  TAG_W  tag of the head entry.

## Operation
- A request is accepted (push) when in_valid && in_ready.
- A result is consumed (pop) when out_valid && out_ready.
- Formats, with s = inst[31] and sign extension to XLEN:
  - 0: all zeros.
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U: sext({inst[31:12], 12'b0}). At XLEN = 32 there are no extension bits.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - CSR: zero-extended inst[19:15].
  - SHAMT: zero-extended inst[25:20]. At XLEN = 32, bit 5 is forced to 0.
- The immediate is computed combinationally from the in_* inputs and written into the buffer on push. The buffer stores only imm and tag, never the raw instruction.
- Buffer structure:
  - 2-entry circular FIFO with wr_ptr, rd_ptr (1 bit each) and count (0..2).
  - out_imm and out_tag are driven directly from the head entry.
  - out_imm and out_tag are don't-care when out_valid = 0.
- in_ready = (count != 2). It depends only on state and is never combinational on out_ready.
- out_valid = (count != 0).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Push while count = 2 cannot occur because in_ready = 0. Pop while count = 0 cannot occur.
- Pointers wrap 1 → 0.
- flush:
  - Next cycle: count = 0, wr_ptr = rd_ptr = 0.
  - flush has priority over any same-cycle push or pop. The push is dropped even if in_ready = 1.
- rstn low at any time, including mid-transfer:
  - Immediately: count = 0, both pointers = 0, out_valid = 0, in_ready = 1.
  - Buffer data storage is not reset.

## Timing
- Latency is 1 cycle. A request pushed at edge N appears with out_valid = 1 after edge N, even when the buffer was empty. There is no combinational bypass.
- Throughput is 1 result per cycle when out_ready is held high. In steady state count stays at 1.
- With out_ready = 0, two requests are absorbed and in_ready falls after the second push edge.
- in_ready returns high in the cycle after the first pop.
- out_imm and out_tag hold stable while out_valid = 1 and out_ready = 0.
- Reset values of the outputs: out_valid = 0, in_ready = 1.

## Test plan
- XLEN = 64, op I, inst 0xFFF00093 (addi x1,x0,-1), tag 3 → one cycle later out_valid = 1, out_imm = 0xFFFFFFFFFFFFFFFF, out_tag = 3.
- XLEN = 64, back-to-back ops with out_ready = 1:
  - op B with 0xFE000EE3 → imm = −4 (0xFFFFFFFFFFFFFFFC).
  - op U with 0x800000B7 → imm = 0xFFFFFFFF80000000.
  - op CSR with inst[19:15] = 0x1F → imm = 0x1F.
  - op SHAMT with 0x03F09093 → imm = 63.
  - Required: one result per cycle, in order.
- XLEN = 32:
  - U with 0x800000B7 → 0x80000000.
  - SHAMT with 0x03F09093 → 0x1F.
  - I with 0xFFF00093 → 0xFFFFFFFF.
- Back-pressure: out_ready = 0, issue 3 requests with tags 1, 2, 3.
  - in_ready drops after the 2nd push; tag 3 is held by the source.
  - Raise out_ready: results emerge as tags 1, 2, 3 with no loss or duplication.
- Buffer holding 2 entries; assert flush together with in_valid = 1 and out_ready = 1 → next cycle out_valid = 0, in_ready = 1, and the flushed and same-cycle requests never appear.
- Hold 1 entry, then pulse rstn low asynchronously between edges → out_valid falls immediately. After release, a new request with tag 5 emerges correctly one cycle after acceptance.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry valid/ready output buffer.
// Decodes one instruction per cycle into an XLEN-wide immediate and queues it with its tag.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : gen_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam bit Is32 = (XLEN == 32);

  logic [63:0]      imm64;
  logic [XLEN-1:0]  imm;
  logic             push;
  logic             pop;

  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [XLEN-1:0]  mem_imm_q [2];
  logic [XLEN-1:0]  mem_imm_d [2];
  logic [TAG_W-1:0] mem_tag_q [2];
  logic [TAG_W-1:0] mem_tag_d [2];

  // Build every format at 64 bits and truncate, so XLEN=32 needs no zero-width replications.
  always_comb begin
    imm64 = '0;
    unique case (in_op)
      3'd0: imm64 = '0;
      3'd1: imm64 = {{52{in_inst[31]}}, in_inst[31:20]};
      3'd2: imm64 = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      3'd3: imm64 = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
      3'd4: imm64 = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
      3'd5: imm64 = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                     in_inst[30:21], 1'b0};
      3'd6: imm64 = {59'b0, in_inst[19:15]};
      3'd7: imm64 = {58'b0, (Is32 ? 1'b0 : in_inst[25]), in_inst[24:20]};
    endcase
  end

  assign imm = imm64[XLEN-1:0];

  logic unused_bits;
  assign unused_bits = ^{in_inst[6:0], imm64};

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_imm   = mem_imm_q[rd_ptr_q];
  assign out_tag   = mem_tag_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_imm_d = mem_imm_q;
    mem_tag_d = mem_tag_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_imm_d[wr_ptr_q] = imm;
        mem_tag_d[wr_ptr_q] = in_tag;
        wr_ptr_d            = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is intentionally not reset.
  always_ff @(posedge clk) begin
    mem_imm_q <= mem_imm_d;
    mem_tag_q <= mem_tag_d;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances share one stimulus
// stream; a scoreboard queue tracks accepted requests and checks results in order.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [31:0] in_inst;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        in_ready64, in_ready32;
  logic        out_valid64, out_valid32;
  logic [63:0] out_imm64;
  logic [31:0] out_imm32;
  logic [3:0]  out_tag64, out_tag32;

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready64),
    .in_op     (in_op),
    .in_inst   (in_inst),
    .in_tag    (in_tag),
    .out_valid (out_valid64),
    .out_ready (out_ready),
    .out_imm   (out_imm64),
    .out_tag   (out_tag64)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready32),
    .in_op     (in_op),
    .in_inst   (in_inst),
    .in_tag    (in_tag),
    .out_valid (out_valid32),
    .out_ready (out_ready),
    .out_imm   (out_imm32),
    .out_tag   (out_tag32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] inst;
    logic [3:0]  tag;
    logic [63:0] e64;
    logic [31:0] e32;
  } vec_t;

  typedef struct {
    logic [63:0] e64;
    logic [31:0] e32;
    logic [3:0]  tag;
  } sb_t;

  vec_t        tbl [10];
  sb_t         sbq [$];
  sb_t         cur;
  int          n_vec = 0;
  int          n_err = 0;
  bit          rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference decode written from the format definitions using signed extension.
  function automatic logic [63:0] model64(input logic [2:0] op, input logic [31:0] in);
    logic signed [63:0] r;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    r = '0;
    case (op)
      3'd1: begin i12 = in[31:20]; r = i12; end
      3'd2: begin i12 = {in[31:25], in[11:7]}; r = i12; end
      3'd3: begin b13 = {in[31], in[7], in[30:25], in[11:8], 1'b0}; r = b13; end
      3'd4: begin u32 = {in[31:12], 12'h000}; r = u32; end
      3'd5: begin j21 = {in[31], in[19:12], in[20], in[30:21], 1'b0}; r = j21; end
      3'd6: r = {59'd0, in[19:15]};
      3'd7: r = {58'd0, in[25:20]};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] model32(input logic [2:0] op, input logic [31:0] in);
    logic [63:0] r;
    r = model64(op, in);
    if (op == 3'd7) r[5] = 1'b0;
    return r[31:0];
  endfunction

  task automatic send(input logic [2:0] op, input logic [31:0] inst, input logic [3:0] tag,
                      input logic [63:0] e64, input logic [31:0] e32, output int cycles);
    bit got;
    in_valid = 1'b1;
    in_op    = op;
    in_inst  = inst;
    in_tag   = tag;
    cur.e64  = e64;
    cur.e32  = e32;
    cur.tag  = tag;
    cycles   = 0;
    got      = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      got = in_ready64;
      @(posedge clk);
      #1;
      cycles++;
      if (got) break;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [3:0] tag);
    logic [2:0]  op;
    logic [31:0] inst;
    int          cyc;
    op   = 3'($urandom_range(0, 7));
    inst = $urandom;
    send(op, inst, tag, model64(op, inst), model32(op, inst), cyc);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    tbl[0] = '{3'd1, 32'hFFF00093, 4'd3, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF};
    tbl[1] = '{3'd3, 32'hFE000EE3, 4'd1, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC};
    tbl[2] = '{3'd4, 32'h800000B7, 4'd2, 64'hFFFFFFFF80000000, 32'h80000000};
    tbl[3] = '{3'd6, 32'h000F8073, 4'd4, 64'h000000000000001F, 32'h0000001F};
    tbl[4] = '{3'd7, 32'h03F09093, 4'd5, 64'h000000000000003F, 32'h0000001F};
    tbl[5] = '{3'd2, 32'hFE112E23, 4'd6, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC};
    tbl[6] = '{3'd5, 32'h0080006F, 4'd7, 64'h0000000000000008, 32'h00000008};
    tbl[7] = '{3'd0, 32'hFFFFFFFF, 4'd8, 64'h0000000000000000, 32'h00000000};
    tbl[8] = '{3'd5, 32'hFFDFF06F, 4'd9, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC};
    tbl[9] = '{3'd1, 32'h7FF00093, 4'hA, 64'h00000000000007FF, 32'h000007FF};

    rstn      = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_inst   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    cur       = '{64'd0, 32'd0, 4'd0};

    // Scoreboard monitor, sampling on the falling edge.
    fork
      forever begin
        sb_t e;
        @(negedge clk);
        if (!rstn) begin
          sbq.delete();
          chk("rst_out_valid", 64'(out_valid64), 64'd0);
          chk("rst_in_ready", 64'(in_ready64), 64'd1);
        end else begin
          chk("in_ready", 64'(in_ready64), 64'(sbq.size() != 2));
          chk("out_valid", 64'(out_valid64), 64'(sbq.size() != 0));
          chk("out_valid32", 64'(out_valid32), 64'(sbq.size() != 0));
          if (flush) begin
            sbq.delete();
          end else begin
            if (out_valid64 && out_ready && sbq.size() != 0) begin
              e = sbq.pop_front();
              chk("imm64", out_imm64, e.e64);
              chk("imm32", 64'(out_imm32), 64'(e.e32));
              chk("tag64", 64'(out_tag64), 64'(e.tag));
              chk("tag32", 64'(out_tag32), 64'(e.tag));
            end
            if (in_valid && in_ready64) sbq.push_back(cur);
          end
        end
      end
    join_none

    #2 rstn = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid64), 64'd0);
    chk("reset_in_ready", 64'(in_ready64), 64'd1);
    chk("reset_in_ready32", 64'(in_ready32), 64'd1);
    #19 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single request, one-cycle latency.
    out_ready = 1'b1;
    send(tbl[0].op, tbl[0].inst, tbl[0].tag, tbl[0].e64, tbl[0].e32, cyc);
    chk("lat_out_valid", 64'(out_valid64), 64'd1);
    chk("lat_imm", out_imm64, tbl[0].e64);
    chk("lat_tag", 64'(out_tag64), 64'd3);

    // Back-to-back table vectors at full throughput.
    for (int i = 1; i < 10; i++) begin
      send(tbl[i].op, tbl[i].inst, tbl[i].tag, tbl[i].e64, tbl[i].e32, cyc);
      chk("b2b_accept_cycles", 64'(cyc), 64'd1);
      chk("b2b_out_valid", 64'(out_valid64), 64'd1);
    end
    drain();

    // Back-pressure: two absorbed, third held by the source.
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    send_rand(4'd1);
    chk("bp_ready_after1", 64'(in_ready64), 64'd1);
    send_rand(4'd2);
    chk("bp_ready_after2", 64'(in_ready64), 64'd0);
    in_valid = 1'b1;
    in_op    = 3'd1;
    in_inst  = 32'h00300093;
    in_tag   = 4'd3;
    cur      = '{64'd3, 32'd3, 4'd3};
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_hold_tag", 64'(out_tag64), 64'd1);
      chk("bp_hold_ready", 64'(in_ready64), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ready_after_pop", 64'(in_ready64), 64'd1);
    send(3'd1, 32'h00300093, 4'd3, 64'd3, 32'd3, cyc);
    drain();

    // Flush with a full buffer and a same-cycle push and pop.
    out_ready = 1'b0;
    send_rand(4'd7);
    send_rand(4'd8);
    in_valid  = 1'b1;
    in_op     = 3'd1;
    in_inst   = 32'hFFF00093;
    in_tag    = 4'd9;
    out_ready = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid64), 64'd0);
    chk("flush_in_ready", 64'(in_ready64), 64'd1);
    repeat (3) @(posedge clk);
    #1;

    // Random traffic with random consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) send_rand(4'(i));
    rand_rdy = 1'b0;
    drain();

    // Asynchronous reset between edges while holding one entry.
    out_ready = 1'b0;
    send_rand(4'd4);
    chk("pre_rst_valid", 64'(out_valid64), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid64), 64'd0);
    chk("async_rst_valid32", 64'(out_valid32), 64'd0);
    chk("async_rst_ready", 64'(in_ready64), 64'd1);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'd6, 32'h00028073, 4'd5, 64'd5, 32'd5, cyc);
    chk("post_rst_valid", 64'(out_valid64), 64'd1);
    chk("post_rst_tag", 64'(out_tag64), 64'd5);
    chk("post_rst_imm", out_imm64, 64'd5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
